// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchronized rx, mid-bit sampling at a run-time
// bit period, 7/8 data bits with optional parity, and host-cleared status flags.
module uart_rx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [18:0] baud_div,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        read_rx,
    output logic [7:0]  data,
    output logic        rxrdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    state_t      state, state_d;
    logic        rx_m, rx_s;
    logic [18:0] cnt, cnt_d;
    logic [3:0]  smp, smp_d;
    logic [7:0]  shreg;
    logic        par;
    logic        eight_l, pen_l, ohel_l;
    logic        expire, start_ok, bit_smp, frame_done;
    logic [3:0]  nbits, last_smp;
    logic        data_bit;
    logic [7:0]  data_fmt;
    logic        perr_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Counter reaching 1 marks the sampling edge, so a load of L samples L clocks later.
    assign expire   = (cnt == 19'd1);
    assign nbits    = eight_l ? 4'd8 : 4'd7;
    assign last_smp = nbits + {3'b000, pen_l};
    assign data_bit = (smp < nbits);
    assign data_fmt = {eight_l & shreg[7], shreg[6:0]};
    assign perr_new = pen_l & (ohel_l ? ~par : par);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 19'd0;
            smp   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            smp   <= smp_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        smp_d      = smp;
        start_ok   = 1'b0;
        bit_smp    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = {1'b0, baud_div[18:1]};
                    state_d = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s) begin
                        cnt_d   = 19'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d    = baud_div;
                        smp_d    = 4'd0;
                        start_ok = 1'b1;
                        state_d  = DATA;
                    end
                end else begin
                    cnt_d = cnt - 19'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    bit_smp = 1'b1;
                    if (smp == last_smp) begin
                        frame_done = 1'b1;
                        cnt_d      = 19'd0;
                        smp_d      = 4'd0;
                        state_d    = IDLE;
                    end else begin
                        smp_d = smp + 4'd1;
                        cnt_d = baud_div;
                    end
                end else begin
                    cnt_d = cnt - 19'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame format is frozen at start validation so mid-frame config changes are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eight_l <= 1'b0;
            pen_l   <= 1'b0;
            ohel_l  <= 1'b0;
            shreg   <= 8'd0;
            par     <= 1'b0;
        end else begin
            if (start_ok) begin
                eight_l <= eight;
                pen_l   <= pen;
                ohel_l  <= ohel;
                shreg   <= 8'd0;
                par     <= 1'b0;
            end else if (bit_smp && !frame_done) begin
                if (data_bit)
                    shreg[smp[2:0]] <= rx_s;
                par <= par ^ rx_s;
            end
        end
    end

    // Completion outranks a simultaneous host read; the read still suppresses overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= 8'd0;
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end else if (frame_done) begin
            data  <= data_fmt;
            perr  <= perr_new;
            ferr  <= ~rx_s;
            rxrdy <= 1'b1;
            ovf   <= read_rx ? 1'b0 : (ovf | rxrdy);
        end else if (read_rx) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: frame-level model with scheduled completions,
// per-cycle output compare, and literal spot checks from the test plan.
module tb_uart_rx_engine;

    logic        clk = 1'b0, reset = 1'b0, rx = 1'b1;
    logic        eight = 1'b1, pen = 1'b0, ohel = 1'b0, read_rx = 1'b0;
    logic [18:0] baud_div = 19'd16;
    logic [7:0]  data;
    logic        rxrdy, perr, ferr, ovf;

    int checks = 0, errors = 0, cyc = 0;
    bit run_cmp = 0;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t     pend[$];
    frame_t     m_f;
    logic [7:0] m_data = 8'd0;
    logic       m_rxrdy = 0, m_perr = 0, m_ferr = 0, m_ovf = 0;

    uart_rx_engine dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_div(baud_div),
        .eight(eight), .pen(pen), .ohel(ohel), .read_rx(read_rx),
        .data(data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    // Model: a frame completes at its scheduled edge; host read clears flags otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = 8'd0; m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            m_f     = pend.pop_front();
            m_ovf   = read_rx ? 1'b0 : (m_ovf | m_rxrdy);
            m_data  = m_f.d;
            m_perr  = m_f.pe;
            m_ferr  = m_f.fe;
            m_rxrdy = 1'b1;
        end else if (read_rx) begin
            m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            checks++;
            if ({data, rxrdy, perr, ferr, ovf} !== {m_data, m_rxrdy, m_perr, m_ferr, m_ovf}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t dut data=%h rdy=%b pe=%b fe=%b ov=%b model data=%h rdy=%b pe=%b fe=%b ov=%b",
                         $time, data, rxrdy, perr, ferr, ovf, m_data, m_rxrdy, m_perr, m_ferr, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        read_rx = 1'b1;
        wait_clk(1);
        read_rx = 1'b0;
    endtask

    // Drives one frame; abort_at >= 0 asserts reset halfway through that data bit.
    task automatic send_frame(input logic [7:0] d, input logic parb, input logic stopb, input int abort_at);
        int         half, nb, n;
        logic [7:0] dm;
        logic       p;
        frame_t     f;
        half = int'(baud_div >> 1);
        nb   = eight ? 8 : 7;
        n    = nb + (pen ? 1 : 0);
        dm   = eight ? d : {1'b0, d[6:0]};
        p    = (^dm) ^ (pen & parb);
        f.due = cyc + 3 + half + (n + 1) * int'(baud_div);
        f.d   = dm;
        f.pe  = pen & (ohel ? ~p : p);
        f.fe  = ~stopb;
        if (abort_at < 0) pend.push_back(f);
        rx = 1'b0;
        wait_clk(int'(baud_div));
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            if (i == abort_at) begin
                wait_clk(half);
                reset = 1'b1;
                wait_clk(1);
                chk("rst_mid_data",  data,  8'h00);
                chk("rst_mid_rxrdy", rxrdy, 8'h00);
                chk("rst_mid_ovf",   ovf,   8'h00);
                chk("rst_mid_flags", {perr, ferr}, 8'h00);
                reset = 1'b0;
                rx = 1'b1;
                wait_clk(4 * int'(baud_div));
                return;
            end
            wait_clk(int'(baud_div));
        end
        if (pen) begin
            rx = parb;
            wait_clk(int'(baud_div));
        end
        rx = stopb;
        wait_clk(int'(baud_div));
        rx = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        run_cmp = 1;
        chk("reset_data", data, 8'h00);
        chk("reset_rxrdy", rxrdy, 8'h00);
        wait_clk(5);

        // 8N1 basic receive and host read
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("a5_data", data, 8'hA5);
        chk("a5_rxrdy", rxrdy, 8'h01);
        chk("a5_flags", {perr, ferr, ovf}, 8'h00);
        pulse_read();
        chk("a5_read_rxrdy", rxrdy, 8'h00);
        chk("a5_read_data", data, 8'hA5);

        // 7-bit with parity
        eight = 1'b0; pen = 1'b1; ohel = 1'b0;
        send_frame(8'h41, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("7e_ok_data", data, 8'h41);
        chk("7e_ok_perr", perr, 8'h00);
        pulse_read();
        send_frame(8'h41, 1'b1, 1'b1, -1);
        wait_clk(2);
        chk("7e_bad_perr", perr, 8'h01);
        pulse_read();
        ohel = 1'b1;
        send_frame(8'h41, 1'b1, 1'b1, -1);
        wait_clk(2);
        chk("7o_ok_perr", perr, 8'h00);
        pulse_read();

        // Framing error, then a good frame replaces ferr
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        wait_clk(2);
        chk("fe_data", data, 8'h3C);
        chk("fe_ferr", ferr, 8'h01);
        chk("fe_rxrdy", rxrdy, 8'h01);
        wait_clk(48);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("fe_next_ferr", ferr, 8'h00);
        chk("fe_next_data", data, 8'h55);
        chk("fe_next_ovf", ovf, 8'h01);

        // False start: 5-clock glitch must not disturb anything
        rx = 1'b0;
        wait_clk(5);
        rx = 1'b1;
        wait_clk(40);
        chk("glitch_rxrdy", rxrdy, 8'h01);
        chk("glitch_ovf", ovf, 8'h01);
        chk("glitch_data", data, 8'h55);
        pulse_read();
        send_frame(8'h12, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("after_glitch_data", data, 8'h12);
        pulse_read();

        // Overrun, then a read coinciding with completion
        send_frame(8'h01, 1'b0, 1'b1, -1);
        send_frame(8'h02, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("ovr_data", data, 8'h02);
        chk("ovr_ovf", ovf, 8'h01);
        fork
            send_frame(8'h03, 1'b0, 1'b1, -1);
            begin
                wait_clk(2 + 8 + 9 * 16);
                read_rx = 1'b1;
                wait_clk(1);
                read_rx = 1'b0;
            end
        join
        wait_clk(2);
        chk("rdcoll_rxrdy", rxrdy, 8'h01);
        chk("rdcoll_ovf", ovf, 8'h00);
        chk("rdcoll_data", data, 8'h03);
        pulse_read();

        // Shortest-ish odd period, 8O1, back to back
        baud_div = 19'd5; pen = 1'b1; ohel = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        send_frame(8'h80, 1'b1, 1'b1, -1);
        wait_clk(10);
        chk("b5_data", data, 8'h80);
        chk("b5_perr", perr, 8'h01);
        chk("b5_ovf", ovf, 8'h01);

        // Reset mid data bit 4, then a clean frame
        baud_div = 19'd16; pen = 1'b0; ohel = 1'b0;
        wait_clk(20);
        send_frame(8'h99, 1'b0, 1'b1, 4);
        send_frame(8'hC3, 1'b0, 1'b1, -1);
        wait_clk(2);
        chk("post_rst_data", data, 8'hC3);
        chk("post_rst_rxrdy", rxrdy, 8'h01);
        wait_clk(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
